wm_led_panel: RTL and testbench
===============================

Name: wm_led_panel

Overview:
- Autonomous LED-panel sequencer for the washing-machine demo board. It has no user inputs.
- Steps the front-panel indicators through a complete program: water-level select, temperature select, wash, rinse (with repeat), dry, done.
- After each program it advances to the next water/temperature combination, cycling through all 9 combinations.
- Instantiated by the board top, driving 6 red stage LEDs and 6 green option LEDs directly.

Parameters:
- STEP_CYCLES, 125_000_000: clock cycles per step (1 s at 125 MHz); must be >= 2.
- WASH_STEPS, 3: steps spent in wash.
- RINSE_STEPS, 2: steps per rinse pass.
- RINSE_COUNT, 2: number of rinse passes; must be >= 1.
- DRY_STEPS, 2: steps spent in dry.

Ports:
- clk  in  1  system clock, 125 MHz.
- rstn  in  1  asynchronous active-low reset.
- red_led_wash  out  1  wash stage active.
- red_led_rinse  out  1  rinse stage active.
- red_led_dry  out  1  dry stage active.
- red_led_repeat  out  1  rinse repeat pass (pass 2..RINSE_COUNT) active.
- red_led_water_height  out  1  water-height selection stage.
- red_led_hot_cold  out  1  temperature selection stage.
- green_led_water_high  out  1  selected water level high.
- green_led_water_mid  out  1  selected water level mid.
- green_led_water_low  out  1  selected water level low.
- green_led_hot_only  out  1  selected temperature hot only.
- green_led_cold_only  out  1  selected temperature cold only.
- green_led_hot_cold  out  1  selected temperature hot+cold.

Behaviour:
- Reset (rstn=0, asynchronous):
  - All 12 outputs 0.
  - state=S_WATER, water_sel=HIGH, temp_sel=HOT_ONLY.
  - Step timer=0, step count=0, rinse pass=1.
- Step timer: counts 0..STEP_CYCLES-1 and issues a one-cycle tick at the terminal count. Phase transitions occur only on tick.
- States and durations in steps:
  - S_WATER (1)
  - S_TEMP (1)
  - S_WASH (WASH_STEPS)
  - S_RINSE (RINSE_STEPS x RINSE_COUNT)
  - S_DRY (DRY_STEPS)
  - S_DONE (1)
  - then back to S_WATER.
- Rinse: the pass counter increments every RINSE_STEPS ticks. Leave S_RINSE when pass RINSE_COUNT completes.
- On S_DONE exit, advance the selection:
  - water_sel: HIGH -> MID -> LOW -> HIGH.
  - When water_sel wraps LOW->HIGH, temp_sel advances: HOT_ONLY -> COLD_ONLY -> HOT_COLD -> HOT_ONLY.
  - The full cycle is 9 programs, then it repeats.
- Output decode (all outputs registered, one cycle after the state register):
  - S_WATER: red_led_water_height=1; the water_sel green LED=1; temperature greens=0.
  - S_TEMP: red_led_hot_cold=1; the water and temp green LEDs each one-hot on.
  - S_WASH / S_RINSE / S_DRY: the matching red LED=1; both green groups hold the selection.
  - red_led_repeat=1 only in S_RINSE with pass>=2, alongside red_led_rinse.
  - S_DONE: all outputs 0.
- Invariants:
  - At most one of red wash/rinse/dry/water_height/hot_cold is high at any time.
  - Each green group is one-hot or all-zero.
- Reset mid-program clears outputs immediately and restarts at S_WATER / HIGH / HOT_ONLY.

Optional Feature:
- WM_LED_BLINK_EN defined: the active-stage red LED (the one of wash/rinse/dry/water_height/hot_cold that is high) is lit only for timer < STEP_CYCLES/2 of each step and dark for the rest of the step. red_led_repeat and the greens stay steady.
- Undefined: all LEDs steady as decoded.

Decomposition:
- Package wm_led_pkg holds:
  - state enum (S_WATER, S_TEMP, S_WASH, S_RINSE, S_DRY, S_DONE);
  - water enum (HIGH, MID, LOW);
  - temp enum (HOT_ONLY, COLD_ONLY, HOT_COLD);
  - default step constants.
- One sub-module, wm_step_timer: parameterised prescaler producing the step tick and the current timer value. The sequencer FSM and output decode stay in wm_led_panel.

Test Plan (STEP_CYCLES=10, other parameters default; step n covers cycles 10n..10n+9 after reset release):
- Hold rstn=0 for 1000 ns -> all 12 outputs 0. Assert rstn=0 mid-wash -> outputs 0 asynchronously, restart at S_WATER.
- Step 0 -> red_led_water_height=1, green_led_water_high=1, others 0. Step 1 -> red_led_hot_cold=1, green_led_water_high=1, green_led_hot_only=1.
- Steps 2-4 -> red_led_wash=1 with greens held. Steps 5-6 -> red_led_rinse=1, red_led_repeat=0. Steps 7-8 -> red_led_rinse=1, red_led_repeat=1.
- Steps 9-10 -> red_led_dry=1. Step 11 -> all outputs 0. Step 12 -> green_led_water_mid=1.
- Program 4 (step 36) -> green_led_water_high=1 and, from step 37, green_led_cold_only=1. Program 10 (step 108) returns to the HIGH/HOT_ONLY combination.
- With WM_LED_BLINK_EN -> red_led_wash high for 5 cycles and low for 5 cycles in each wash step; without it, steady high for 30 cycles.

Source files
------------

// File: rtl/wm_led_pkg.sv
// Shared types and default timing for the washing-machine LED panel sequencer.
// Red LED vectors are packed {wash, rinse, dry, repeat, water_height, hot_cold}.
package wm_led_pkg;

  typedef enum logic [2:0] {S_WATER, S_TEMP, S_WASH, S_RINSE, S_DRY, S_DONE} state_e;
  typedef enum logic [1:0] {HIGH, MID, LOW} water_e;
  typedef enum logic [1:0] {HOT_ONLY, COLD_ONLY, HOT_COLD} temp_e;

  localparam int unsigned DEF_STEP_CYCLES = 125_000_000;
  localparam int unsigned DEF_WASH_STEPS  = 3;
  localparam int unsigned DEF_RINSE_STEPS = 2;
  localparam int unsigned DEF_RINSE_COUNT = 2;
  localparam int unsigned DEF_DRY_STEPS   = 2;

  localparam int unsigned RED_WASH   = 5;
  localparam int unsigned RED_RINSE  = 4;
  localparam int unsigned RED_DRY    = 3;
  localparam int unsigned RED_REPEAT = 2;
  localparam int unsigned RED_WATER  = 1;
  localparam int unsigned RED_TEMP   = 0;

  // Green LED patterns: water {high, mid, low}, temperature {hot, cold, hot+cold}.
  function automatic logic [2:0] water_leds(input water_e w);
    case (w)
      HIGH:    return 3'b100;
      MID:     return 3'b010;
      LOW:     return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] temp_leds(input temp_e t);
    case (t)
      HOT_ONLY:  return 3'b100;
      COLD_ONLY: return 3'b010;
      HOT_COLD:  return 3'b001;
      default:   return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/wm_led_panel_if.sv
// LED bundle of the panel: the sequencer drives it (master), board/monitor reads it (slave).
interface wm_led_panel_if;
  logic red_led_wash;
  logic red_led_rinse;
  logic red_led_dry;
  logic red_led_repeat;
  logic red_led_water_height;
  logic red_led_hot_cold;
  logic green_led_water_high;
  logic green_led_water_mid;
  logic green_led_water_low;
  logic green_led_hot_only;
  logic green_led_cold_only;
  logic green_led_hot_cold;

  modport master (
    output red_led_wash, red_led_rinse, red_led_dry, red_led_repeat,
           red_led_water_height, red_led_hot_cold,
           green_led_water_high, green_led_water_mid, green_led_water_low,
           green_led_hot_only, green_led_cold_only, green_led_hot_cold
  );

  modport slave (
    input red_led_wash, red_led_rinse, red_led_dry, red_led_repeat,
          red_led_water_height, red_led_hot_cold,
          green_led_water_high, green_led_water_mid, green_led_water_low,
          green_led_hot_only, green_led_cold_only, green_led_hot_cold
  );
endinterface

// File: rtl/wm_led_panel_step_timer.sv
// Step prescaler: counts 0..STEP_CYCLES-1 and pulses o_tick on the terminal count.
module wm_step_timer #(
  parameter int unsigned STEP_CYCLES = 10,
  localparam int unsigned TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  output logic          o_tick,
  output logic [TW-1:0] o_timer
);

  localparam logic [TW-1:0] LAST = TW'(STEP_CYCLES - 1);

  logic [TW-1:0] r_timer;
  logic          w_last;

  assign w_last = (r_timer == LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_timer <= '0;
    else if (w_last) r_timer <= '0;
    else             r_timer <= r_timer + 1'b1;
  end

  assign o_tick  = w_last;
  assign o_timer = r_timer;

endmodule

// File: rtl/wm_led_panel.sv
// Autonomous LED-panel program sequencer; all LEDs registered one cycle after the state.
// Optional macro WM_LED_BLINK_EN blinks the active-stage red LED in the first half of each step.
module wm_led_panel
  import wm_led_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = DEF_STEP_CYCLES,
  parameter int unsigned WASH_STEPS  = DEF_WASH_STEPS,
  parameter int unsigned RINSE_STEPS = DEF_RINSE_STEPS,
  parameter int unsigned RINSE_COUNT = DEF_RINSE_COUNT,
  parameter int unsigned DRY_STEPS   = DEF_DRY_STEPS
) (
  input  logic clk,
  input  logic rstn,
  output logic red_led_wash,
  output logic red_led_rinse,
  output logic red_led_dry,
  output logic red_led_repeat,
  output logic red_led_water_height,
  output logic red_led_hot_cold,
  output logic green_led_water_high,
  output logic green_led_water_mid,
  output logic green_led_water_low,
  output logic green_led_hot_only,
  output logic green_led_cold_only,
  output logic green_led_hot_cold
);

`ifdef WM_LED_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  localparam int unsigned TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [TW-1:0] HALF = TW'(STEP_CYCLES / 2);
  // Step/pass counters are 8 bits; stage lengths are small board constants.
  localparam logic [7:0] WASH_LAST  = 8'(WASH_STEPS - 1);
  localparam logic [7:0] RINSE_LAST = 8'(RINSE_STEPS - 1);
  localparam logic [7:0] DRY_LAST   = 8'(DRY_STEPS - 1);
  localparam logic [7:0] PASS_LAST  = 8'(RINSE_COUNT);

  logic          w_tick;
  logic [TW-1:0] w_timer;

  state_e     r_state, w_state_nx;
  logic [7:0] r_step,  w_step_nx;
  logic [7:0] r_pass,  w_pass_nx;
  water_e     r_water, w_water_nx;
  temp_e      r_temp,  w_temp_nx;

  logic [5:0] w_red, w_green;
  logic [5:0] r_red, r_green;

  wm_step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_timer (
    .i_clk   (clk),
    .i_rst_n (rstn),
    .o_tick  (w_tick),
    .o_timer (w_timer)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_WATER;
      r_step  <= '0;
      r_pass  <= 8'd1;
      r_water <= HIGH;
      r_temp  <= HOT_ONLY;
    end else begin
      r_state <= w_state_nx;
      r_step  <= w_step_nx;
      r_pass  <= w_pass_nx;
      r_water <= w_water_nx;
      r_temp  <= w_temp_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_step_nx  = r_step;
    w_pass_nx  = r_pass;
    w_water_nx = r_water;
    w_temp_nx  = r_temp;
    if (w_tick) begin
      case (r_state)
        S_WATER: w_state_nx = S_TEMP;
        S_TEMP: begin
          w_state_nx = S_WASH;
          w_step_nx  = '0;
        end
        S_WASH: begin
          if (r_step == WASH_LAST) begin
            w_state_nx = S_RINSE;
            w_step_nx  = '0;
            w_pass_nx  = 8'd1;
          end else w_step_nx = r_step + 8'd1;
        end
        S_RINSE: begin
          // A pass ends every RINSE_STEPS ticks; the last pass leaves the stage.
          if (r_step == RINSE_LAST) begin
            w_step_nx = '0;
            if (r_pass == PASS_LAST) begin
              w_state_nx = S_DRY;
              w_pass_nx  = 8'd1;
            end else w_pass_nx = r_pass + 8'd1;
          end else w_step_nx = r_step + 8'd1;
        end
        S_DRY: begin
          if (r_step == DRY_LAST) begin
            w_state_nx = S_DONE;
            w_step_nx  = '0;
          end else w_step_nx = r_step + 8'd1;
        end
        S_DONE: begin
          w_state_nx = S_WATER;
          w_step_nx  = '0;
          case (r_water)
            HIGH:    w_water_nx = MID;
            MID:     w_water_nx = LOW;
            default: begin
              w_water_nx = HIGH;
              case (r_temp)
                HOT_ONLY:  w_temp_nx = COLD_ONLY;
                COLD_ONLY: w_temp_nx = HOT_COLD;
                default:   w_temp_nx = HOT_ONLY;
              endcase
            end
          endcase
        end
        default: w_state_nx = S_WATER;
      endcase
    end
  end

  always_comb begin
    w_red   = '0;
    w_green = '0;
    case (r_state)
      S_WATER: begin
        w_red[RED_WATER] = 1'b1;
        w_green          = {water_leds(r_water), 3'b000};
      end
      S_TEMP: begin
        w_red[RED_TEMP] = 1'b1;
        w_green         = {water_leds(r_water), temp_leds(r_temp)};
      end
      S_WASH: begin
        w_red[RED_WASH] = 1'b1;
        w_green         = {water_leds(r_water), temp_leds(r_temp)};
      end
      S_RINSE: begin
        w_red[RED_RINSE]  = 1'b1;
        w_red[RED_REPEAT] = (r_pass >= 8'd2);
        w_green           = {water_leds(r_water), temp_leds(r_temp)};
      end
      S_DRY: begin
        w_red[RED_DRY] = 1'b1;
        w_green        = {water_leds(r_water), temp_leds(r_temp)};
      end
      default: ;
    endcase
    // Blinking darkens only the stage LED; repeat and greens stay steady.
    if (BLINK_EN && (w_timer >= HALF)) w_red = w_red & (6'b1 << RED_REPEAT);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_red   <= '0;
      r_green <= '0;
    end else begin
      r_red   <= w_red;
      r_green <= w_green;
    end
  end

  assign {red_led_wash, red_led_rinse, red_led_dry, red_led_repeat,
          red_led_water_height, red_led_hot_cold} = r_red;
  assign {green_led_water_high, green_led_water_mid, green_led_water_low,
          green_led_hot_only, green_led_cold_only, green_led_hot_cold} = r_green;

endmodule

// File: tb/tb_wm_led_panel.sv
// Bench for wm_led_panel with STEP_CYCLES=10; expected LED vectors come from a step-indexed program model.
module tb_wm_led_panel;

  localparam int STEP = 10;
`ifdef WM_LED_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  wm_led_panel_if led_if();

  wm_led_panel #(.STEP_CYCLES(STEP)) dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .red_led_wash         (led_if.red_led_wash),
    .red_led_rinse        (led_if.red_led_rinse),
    .red_led_dry          (led_if.red_led_dry),
    .red_led_repeat       (led_if.red_led_repeat),
    .red_led_water_height (led_if.red_led_water_height),
    .red_led_hot_cold     (led_if.red_led_hot_cold),
    .green_led_water_high (led_if.green_led_water_high),
    .green_led_water_mid  (led_if.green_led_water_mid),
    .green_led_water_low  (led_if.green_led_water_low),
    .green_led_hot_only   (led_if.green_led_hot_only),
    .green_led_cold_only  (led_if.green_led_cold_only),
    .green_led_hot_cold   (led_if.green_led_hot_cold)
  );

  // {wash, rinse, dry, repeat, water_height, hot_cold, high, mid, low, hot, cold, hot+cold}
  logic [11:0] obs;
  assign obs = {led_if.red_led_wash, led_if.red_led_rinse, led_if.red_led_dry,
                led_if.red_led_repeat, led_if.red_led_water_height, led_if.red_led_hot_cold,
                led_if.green_led_water_high, led_if.green_led_water_mid,
                led_if.green_led_water_low, led_if.green_led_hot_only,
                led_if.green_led_cold_only, led_if.green_led_hot_cold};

  logic [11:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Expected LEDs right after the k-th rising edge following reset release.
  function automatic logic [11:0] model(input int k);
    int n, ph, prog, off;
    logic [2:0] wg, tg;
    logic [5:0] red, grn;
    n    = (k - 1) / STEP;
    ph   = (k - 1) % STEP;
    prog = n / 12;
    off  = n % 12;
    wg   = 3'b100 >> (prog % 3);
    tg   = 3'b100 >> ((prog / 3) % 3);
    red  = 6'b0;
    grn  = {wg, tg};
    case (off)
      0:       begin red = 6'b000010; grn = {wg, 3'b000}; end
      1:       red = 6'b000001;
      2, 3, 4: red = 6'b100000;
      5, 6:    red = 6'b010000;
      7, 8:    red = 6'b010100;
      9, 10:   red = 6'b001000;
      default: begin red = 6'b0; grn = 6'b0; end
    endcase
    if (BLINK && ph >= STEP / 2) red = red & 6'b000100;
    return {red, grn};
  endfunction

  task automatic run(input int k_last, output int wash_hi);
    int cnt;
    logic [11:0] e;
    logic inv_ok;
    cnt = 0;
    for (int k = 1; k <= k_last; k++) begin
      @(posedge clk);
      exp_q.push_back(model(k));
      @(negedge clk);
      e = exp_q.pop_front();
      check_eq($sformatf("k%0d_step%0d", k, (k - 1) / STEP), {20'b0, obs}, {20'b0, e});
      inv_ok = ($countones({obs[11:9], obs[7:6]}) <= 1) &&
               ($countones(obs[5:3]) <= 1) && ($countones(obs[2:0]) <= 1);
      check_eq($sformatf("onehot_k%0d", k), {31'b0, inv_ok}, 32'd1);
      if (k >= 21 && k <= 50 && obs[11]) cnt++;
    end
    wash_hi = cnt;
  endtask

  initial begin
    int wash_hi;
    rstn = 1'b0;
    repeat (4) begin
      repeat (25) @(negedge clk);
      check_eq("reset_hold", {20'b0, obs}, 32'd0);
    end
    rstn = 1'b1;
    run(121 * STEP, wash_hi);
    check_eq("wash_high_cycles", wash_hi, BLINK ? 32'd15 : 32'd30);

    rstn = 1'b0;
    #1;
    check_eq("reset_prog_start", {20'b0, obs}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    run(35, wash_hi);
    check_eq("wash_seen_before_reset", {31'b0, (wash_hi > 0)}, 32'd1);
    #2 rstn = 1'b0;
    #1 check_eq("async_reset_mid_wash", {20'b0, obs}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    run(25, wash_hi);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
